// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One result bit per clock, with a start/busy/done handshake and rejection of non-BCD digits.
module bcd2bin_seq #(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic [BIN_W-1:0]  binary,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    localparam int DW = 4 * NDIG;
    localparam int SW = DW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIM
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             busy_q, busy_d;
    logic             erro_q, erro_d;

    logic [SW-1:0]    sh;
    logic             bad_digit;

    // Shift right, then pull every digit that reached 8+ back down by 3.
    always_comb begin
        sh = sr_q >> 1;
        for (int g = 0; g < NDIG; g++) begin
            if (sh[BIN_W+4*g +: 4] >= 4'd8)
                sh[BIN_W+4*g +: 4] = sh[BIN_W+4*g +: 4] - 4'd3;
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int g = 0; g < NDIG; g++) begin
            if (bcd_in[4*g +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        erro_d  = erro_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        erro_d  = 1'b1;
                        bin_d   = '0;
                        state_d = FIM;
                    end else begin
                        sr_d    = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        erro_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_d  = sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bin_d   = sh[BIN_W-1:0];
                    busy_d  = 1'b0;
                    state_d = FIM;
                end
            end
            FIM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            erro_q  <= erro_d;
        end
    end

    // Every BCD digit must be fully drained once the last bit is shifted out.
    always @(posedge clk) begin
        if (rst_n && state_q == SHIFT && cnt_q == LAST)
            assert (sh[SW-1:BIN_W] == '0);
    end

    assign binary = bin_q;
    assign busy   = busy_q;
    assign erro   = erro_q;
    assign done   = (state_q == FIM);

endmodule
